// File: rtl/tem_pulse_gen_pkg.sv
// tem_pulse_pkg: shared types and constants for the TEM-triggered pulse generator.
package tem_pulse_pkg;

    // Per-channel sequencing state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } ch_state_t;

    // Default K1 pulse width inherited from the single-channel generator.
    localparam int unsigned DEF_WIDTH = 4000;

endpackage

// File: rtl/tem_pulse_gen_if.sv
// tem_pulse_gen_if: control, configuration and drive signals of tem_pulse_gen.
// The slave modport is the generator side; the master modport is the controller side.
interface tem_pulse_gen_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MISS_W = 8
);
    logic                       enable;
    logic                       tem;
    logic [NUM_CH*CNT_W-1:0]    delay_cfg;
    logic [NUM_CH*CNT_W-1:0]    width_cfg;
    logic [NUM_CH-1:0]          k_out;
    logic [NUM_CH-1:0]          busy;
    logic [NUM_CH-1:0]          done;
    logic [NUM_CH*MISS_W-1:0]   miss_cnt;

    modport slave (
        input  enable, tem, delay_cfg, width_cfg,
        output k_out, busy, done, miss_cnt
    );

    modport master (
        output enable, tem, delay_cfg, width_cfg,
        input  k_out, busy, done, miss_cnt
    );
endinterface

// File: rtl/tem_pulse_gen_ch.sv
// tem_pulse_ch: one output channel -- delay/pulse sequencer, config latch and
// saturating missed-trigger counter.
module tem_pulse_ch
    import tem_pulse_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MISS_W = 8,
    parameter int unsigned RETRIG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              trig,
    input  logic [CNT_W-1:0]  delay_cfg,
    input  logic [CNT_W-1:0]  width_cfg,
    output logic              k,
    output logic              busy,
    output logic              done,
    output logic [MISS_W-1:0] miss
);

    ch_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   w_q, w_d;
    logic               done_q, done_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               accept;
    logic               miss_inc;

    // State, counter, latched width, done strobe and miss counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            done_q  <= 1'b0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
        end
    end

    // Next-state logic: normal phase progression first, then a trigger
    // acceptance overrides it (so a trigger on the last pulse cycle still
    // leaves done set from the completed pulse).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        done_d   = 1'b0;
        miss_d   = miss_q;
        accept   = 1'b0;
        miss_inc = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    accept = trig;
                end
                DELAY: begin
                    if (trig) begin
                        miss_inc = 1'b1;
                        accept   = (RETRIG != 0);
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = PULSE;
                        cnt_d   = w_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        accept  = trig;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (trig) begin
                            miss_inc = 1'b1;
                            accept   = (RETRIG != 0);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (accept) begin
                w_d = width_cfg;
                if (width_cfg == '0) begin
                    state_d = IDLE;
                end else if (delay_cfg == '0) begin
                    state_d = PULSE;
                    cnt_d   = width_cfg;
                end else begin
                    state_d = DELAY;
                    cnt_d   = delay_cfg;
                end
            end

            if (miss_inc && (miss_q != '1)) begin
                miss_d = miss_q + MISS_W'(1);
            end
        end
    end

    assign k    = (state_q == PULSE);
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign miss = miss_q;

endmodule

// File: rtl/tem_pulse_gen.sv
// tem_pulse_gen: TEM rising-edge detector driving NUM_CH independent
// delay/width pulse channels (K1 = ch0, K2 = ch1, ...).
// Build option TEM_SYNC_EN: adds a 2-flop synchronizer on tem (+2 cycles latency).
module tem_pulse_gen
    import tem_pulse_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned RETRIG = 0,
    parameter int unsigned MISS_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    tem_pulse_gen_if.slave  bus
);

    logic               tem_s;
    logic               tem_q;
    logic               trig;
    logic [NUM_CH-1:0]  k_vec;
    logic [NUM_CH-1:0]  busy_vec;
    logic [NUM_CH-1:0]  done_vec;
    logic [NUM_CH*MISS_W-1:0] miss_vec;

`ifdef TEM_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.tem};
        end
    end

    assign tem_s = sync_q[1];
`else
    assign tem_s = bus.tem;
`endif

    // Rising-edge detect; tem_q tracks regardless of enable so a level held
    // across enable rising is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tem_q <= 1'b0;
            trig  <= 1'b0;
        end else begin
            tem_q <= tem_s;
            trig  <= tem_s & ~tem_q & bus.enable;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tem_pulse_ch #(
            .CNT_W  (CNT_W),
            .MISS_W (MISS_W),
            .RETRIG (RETRIG)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (bus.enable),
            .trig      (trig),
            .delay_cfg (bus.delay_cfg[i*CNT_W +: CNT_W]),
            .width_cfg (bus.width_cfg[i*CNT_W +: CNT_W]),
            .k         (k_vec[i]),
            .busy      (busy_vec[i]),
            .done      (done_vec[i]),
            .miss      (miss_vec[i*MISS_W +: MISS_W])
        );
    end

    assign bus.k_out    = k_vec;
    assign bus.busy     = busy_vec;
    assign bus.done     = done_vec;
    assign bus.miss_cnt = miss_vec;

endmodule

// File: tb/tb_tem_pulse_gen.sv
// tb_tem_pulse_gen: directed bench for tem_pulse_gen; dut0 ignores retriggers,
// dut1 restarts. Both see identical stimulus.
module tb_tem_pulse_gen;
    import tem_pulse_pkg::*;

`ifdef TEM_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        tem = 1'b0;
    logic [31:0] dcfg = '0;
    logic [31:0] wcfg = '0;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    tem_pulse_gen_if #(.NUM_CH(2), .CNT_W(16), .MISS_W(8)) bus0 ();
    tem_pulse_gen_if #(.NUM_CH(2), .CNT_W(16), .MISS_W(8)) bus1 ();

    assign bus0.enable = enable;
    assign bus0.tem = tem;
    assign bus0.delay_cfg = dcfg;
    assign bus0.width_cfg = wcfg;
    assign bus1.enable = enable;
    assign bus1.tem = tem;
    assign bus1.delay_cfg = dcfg;
    assign bus1.width_cfg = wcfg;

    tem_pulse_gen #(.NUM_CH(2), .CNT_W(16), .RETRIG(0), .MISS_W(8)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    tem_pulse_gen #(.NUM_CH(2), .CNT_W(16), .RETRIG(1), .MISS_W(8)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         off;
        logic [1:0] k;
        logic [1:0] busy;
        logic [1:0] done;
    } vec_t;

    vec_t tbl[10];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] k, input logic [1:0] b, input logic [1:0] d);
        chk({tag, " dut0 k_out"}, 32'(bus0.k_out), 32'(k));
        chk({tag, " dut0 busy"},  32'(bus0.busy),  32'(b));
        chk({tag, " dut0 done"},  32'(bus0.done),  32'(d));
        chk({tag, " dut1 k_out"}, 32'(bus1.k_out), 32'(k));
        chk({tag, " dut1 busy"},  32'(bus1.busy),  32'(b));
        chk({tag, " dut1 done"},  32'(bus1.done),  32'(d));
    endtask

    initial begin
        int n0;
        int hi0, dn0, hi1, dn1, k1hi, d1hi;

        // Basic test expectations, offsets from the edge at which tem rises.
        tbl[0] = '{1,    2'b00, 2'b00, 2'b00};
        tbl[1] = '{2,    2'b01, 2'b11, 2'b00};
        tbl[2] = '{11,   2'b01, 2'b11, 2'b00};
        tbl[3] = '{12,   2'b11, 2'b11, 2'b00};
        tbl[4] = '{16,   2'b11, 2'b11, 2'b00};
        tbl[5] = '{17,   2'b01, 2'b01, 2'b10};
        tbl[6] = '{18,   2'b01, 2'b01, 2'b00};
        tbl[7] = '{4001, 2'b01, 2'b01, 2'b00};
        tbl[8] = '{4002, 2'b00, 2'b00, 2'b01};
        tbl[9] = '{4003, 2'b00, 2'b00, 2'b00};

        // Reset state
        dcfg = {16'd10, 16'd0};
        wcfg = {16'd5, 16'(DEF_WIDTH)};
        repeat (3) step();
        chk_outs("reset", 2'b00, 2'b00, 2'b00);
        chk("reset dut0 miss", 32'(bus0.miss_cnt), 32'h0);
        chk("reset dut1 miss", 32'(bus1.miss_cnt), 32'h0);
        rst = 1'b0;
        step();
        enable = 1'b1;
        repeat (3) step();

        // Basic: ch0 d=0 w=4000, ch1 d=10 w=5
        n0 = cyc;
        tem = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adv_to(n0 + tbl[i].off + LAT);
            chk_outs($sformatf("basic[%0d]", i), tbl[i].k, tbl[i].busy, tbl[i].done);
        end
        tem = 1'b0;
        repeat (4) step();
        chk("basic dut0 miss", 32'(bus0.miss_cnt), 32'h0);

        // Retrigger at pulse cycle 50: dut0 ignores, dut1 restarts; ch1 w=0
        dcfg = {16'd0, 16'd0};
        wcfg = {16'd0, 16'd100};
        hi0 = 0; dn0 = 0; hi1 = 0; dn1 = 0; k1hi = 0; d1hi = 0;
        n0 = cyc;
        tem = 1'b1;
        for (int c = 1; c <= 160 + LAT; c++) begin
            step();
            if (c == 1) tem = 1'b0;
            if (c == 50) tem = 1'b1;
            if (c == 51) tem = 1'b0;
            hi0 += int'(bus0.k_out[0]);
            dn0 += int'(bus0.done[0]);
            hi1 += int'(bus1.k_out[0]);
            dn1 += int'(bus1.done[0]);
            k1hi += int'(bus0.k_out[1]) + int'(bus1.k_out[1]);
            d1hi += int'(bus0.done[1]) + int'(bus1.done[1]);
            if (c == 101 + LAT) begin
                chk("ign last cycle dut0 k0", 32'(bus0.k_out[0]), 32'h1);
            end
            if (c == 102 + LAT) begin
                chk("ign end dut0 k0", 32'(bus0.k_out[0]), 32'h0);
                chk("ign end dut0 done", 32'(bus0.done), 32'h1);
                chk("rst mid dut1 k0", 32'(bus1.k_out[0]), 32'h1);
                chk("rst mid dut1 done", 32'(bus1.done), 32'h0);
            end
            if (c == 151 + LAT) begin
                chk("rst last cycle dut1 k0", 32'(bus1.k_out[0]), 32'h1);
            end
            if (c == 152 + LAT) begin
                chk("rst end dut1 k0", 32'(bus1.k_out[0]), 32'h0);
                chk("rst end dut1 done", 32'(bus1.done), 32'h1);
            end
        end
        chk("ign dut0 high cycles", 32'(hi0), 32'd100);
        chk("ign dut0 done count", 32'(dn0), 32'd1);
        chk("rst dut1 high cycles", 32'(hi1), 32'd150);
        chk("rst dut1 done count", 32'(dn1), 32'd1);
        chk("zero width ch1 k", 32'(k1hi), 32'd0);
        chk("zero width ch1 done", 32'(d1hi), 32'd0);
        chk("ign dut0 miss", 32'(bus0.miss_cnt), 32'h0001);
        chk("rst dut1 miss", 32'(bus1.miss_cnt), 32'h0001);

        // Saturation: long pulse plus 300 extra edges
        wcfg = {16'd0, 16'd60000};
        tem = 1'b1; step(); tem = 1'b0; step();
        for (int e = 0; e < 300; e++) begin
            tem = 1'b1; step(); tem = 1'b0; step();
        end
        repeat (5) step();
        chk("sat dut0 miss", 32'(bus0.miss_cnt), 32'h00FF);
        chk("sat dut1 miss", 32'(bus1.miss_cnt), 32'h00FF);
        chk_outs("sat active", 2'b01, 2'b01, 2'b00);

        // Enable drop truncates without done; miss holds
        enable = 1'b0;
        step();
        chk_outs("en drop", 2'b00, 2'b00, 2'b00);
        step();
        chk_outs("en drop +1", 2'b00, 2'b00, 2'b00);
        chk("en drop dut0 miss", 32'(bus0.miss_cnt), 32'h00FF);

        // Level already high when enable rises: no pulse
        wcfg = {16'd0, 16'd20};
        tem = 1'b1;
        repeat (4) step();
        enable = 1'b1;
        repeat (10) step();
        chk_outs("level", 2'b00, 2'b00, 2'b00);
        tem = 1'b0;
        repeat (4) step();

        // ch0 zero width, ch1 in DELAY when async reset hits mid-cycle
        dcfg = {16'd20, 16'd0};
        wcfg = {16'd5, 16'd0};
        n0 = cyc;
        tem = 1'b1; step(); tem = 1'b0;
        adv_to(n0 + 2 + LAT);
        chk_outs("zw delay", 2'b00, 2'b10, 2'b00);
        adv_to(n0 + 5 + LAT);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("async rst", 2'b00, 2'b00, 2'b00);
        chk("async rst dut0 miss", 32'(bus0.miss_cnt), 32'h0);
        #2;
        rst = 1'b0;
        repeat (3) step();

        // First trigger after reset release
        dcfg = {16'd3, 16'd0};
        wcfg = {16'd2, 16'd0};
        n0 = cyc;
        tem = 1'b1; step(); tem = 1'b0;
        adv_to(n0 + 4 + LAT);
        chk_outs("post rst pre", 2'b00, 2'b10, 2'b00);
        adv_to(n0 + 5 + LAT);
        chk_outs("post rst k", 2'b10, 2'b10, 2'b00);
        adv_to(n0 + 6 + LAT);
        chk_outs("post rst k2", 2'b10, 2'b10, 2'b00);
        adv_to(n0 + 7 + LAT);
        chk_outs("post rst done", 2'b00, 2'b00, 2'b10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tem_pulse_gen.md
Name: tem_pulse_gen

Overview:
- Parametrised successor to the single-channel TEM-triggered K1 pulse generator.
- Detects the rising edge of the TEM trigger. Fires NUM_CH independent output pulses (K1, K2, ...), each with its own runtime-programmable delay and width.
- Retrigger policy is selectable. Dropped triggers are counted.
- Sits between the TEM comparator input and the relay/switch drive pins on the test PCB.

Parameters:
- NUM_CH, 2, number of output channels (K1 = ch0, K2 = ch1, ...).
- CNT_W, 16, width of delay/width/counter fields.
- RETRIG, 0, 0 = triggers during an active channel are ignored and counted; 1 = an active channel restarts.
- MISS_W, 8, width of each saturating missed-trigger counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global enable; low forces all channels idle and all outputs low.
- tem  in  1  trigger input; a rising edge starts all channels.
- delay_cfg  in  NUM_CH*CNT_W  per-channel delay in clk cycles; ch i at bits [i*CNT_W +: CNT_W].
- width_cfg  in  NUM_CH*CNT_W  per-channel pulse width in clk cycles; same packing.
- k_out  out  NUM_CH  pulse outputs; bit0 = K1, bit1 = K2.
- busy  out  NUM_CH  channel is in DELAY or PULSE.
- done  out  NUM_CH  one-cycle strobe when a channel's pulse ends normally.
- miss_cnt  out  NUM_CH*MISS_W  per-channel saturating count of ignored/restarted triggers.

Behaviour:
- Reset (async, rst high): all outputs 0, all channels IDLE, tem_q = 0, trig = 0, miss_cnt = 0.
- Edge detect:
  - tem_q <= tem every cycle, regardless of enable.
  - trig <= tem & ~tem_q & enable, registered.
  - A level already high when enable rises does not trigger.
- Per-channel FSM with states IDLE, DELAY, PULSE. A channel sees trig on cycle T.
  - IDLE + trig: latch d = delay_cfg and w = width_cfg.
    - w == 0: stay IDLE; no pulse, no done.
    - d == 0: go to PULSE; k high from T+1.
    - d > 0: go to DELAY with cnt = d.
  - DELAY: cnt decrements each cycle. Leaving DELAY at cnt == 1 puts k high exactly d cycles after the d == 0 case.
  - PULSE: k high for exactly w cycles. Then k goes low, done is high for 1 cycle, state returns to IDLE.
- Latency: tem sampled high at edge N → trig at N+1 → k rises at N+2+d.
- Configuration is latched only on trigger acceptance. Changes mid-pulse have no effect.
- Trigger while busy, RETRIG = 0: ignored; miss_cnt increments.
- Trigger while busy, RETRIG = 1: config is relatched and miss_cnt increments.
  - d == 0: stay/enter PULSE with a fresh width count; k stays high, no glitch.
  - d > 0: k drops and the channel enters DELAY.
  - done is not emitted for the aborted pulse.
- Trigger on the same cycle a pulse ends (last PULSE cycle): the end completes (done = 1), then the trigger is treated as an IDLE acceptance. No miss is counted.
- miss_cnt saturates at 2^MISS_W - 1 and never wraps.
- enable low: next cycle all channels go IDLE and k_out = busy = done = 0. miss_cnt holds. A pulse in progress is truncated without done.
- Delays/widths up to 2^CNT_W - 1. Counters never wrap mid-phase.

Optional Feature:
- Macro TEM_SYNC_EN.
- Defined: tem passes through a 2-flop synchronizer (reset to 0) before edge detection; latency +2 cycles (k rises at N+4+d).
- Undefined: tem is used directly; tem must be synchronous to clk.

Decomposition:
- Package tem_pulse_pkg: channel state enum (IDLE, DELAY, PULSE) and default width constant 4000.
- Sub-module tem_pulse_ch:
  - Contains one channel's FSM, counter, config latch and miss counter.
  - Instantiated NUM_CH times in a generate loop.
  - Top holds the synchronizer, edge detect and packing.

Test Plan:
- Reset/basic: rst pulse, enable = 1, ch0 d = 0 w = 4000, ch1 d = 10 w = 5; tem rises at edge N → k_out[0] high N+2..N+4001; k_out[1] high N+12..N+16; done strobes at N+4002 and N+17.
- Ignore mode (RETRIG = 0): w = 100, second tem edge at pulse cycle 50 → pulse still 100 cycles; miss_cnt = 1; 300 extra edges → miss_cnt saturates at 255.
- Restart mode (RETRIG = 1): d = 0 w = 100, retrigger at cycle 50 → k high 150 cycles continuous, one done, miss_cnt = 1.
- Enable drop and level: enable low at pulse cycle 20 → k = 0 next cycle, no done; tem held high while enable rises → no pulse.
- Zero width and async reset: w = 0 → no pulse, no done; rst asserted mid-DELAY between clock edges → outputs 0 immediately; first trigger after release works normally.
- TEM_SYNC_EN build: repeat the basic test → all edges shifted +2 cycles.
